// File: rtl/sata_link_supervisor_pkg.sv
// Shared state encoding and small helpers for the SATA link supervisor.
package sata_link_supervisor_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] SUP_IDLE      = 3'd0;
    localparam logic [STATE_W-1:0] SUP_OFFLINE   = 3'd1;
    localparam logic [STATE_W-1:0] SUP_RESET     = 3'd2;
    localparam logic [STATE_W-1:0] SUP_WAIT_LINK = 3'd3;
    localparam logic [STATE_W-1:0] SUP_LINK_UP   = 3'd4;
    localparam logic [STATE_W-1:0] SUP_FAILED    = 3'd5;
    localparam logic [STATE_W-1:0] SUP_HOLD      = 3'd6;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = SUP_IDLE,
        ST_OFFLINE   = SUP_OFFLINE,
        ST_RESET     = SUP_RESET,
        ST_WAIT_LINK = SUP_WAIT_LINK,
        ST_LINK_UP   = SUP_LINK_UP,
        ST_FAILED    = SUP_FAILED,
        ST_HOLD      = SUP_HOLD
    } sup_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sata_link_supervisor_timer.sv
// State-dwell timer: cleared on state entry, saturates instead of wrapping,
// and flags the two terminal counts the supervisor cares about.
module sup_timer #(
    parameter int TIMER_W = 20,
    parameter int TC_A    = 74,
    parameter int TC_B    = 749999
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic tc_a_o,
    output logic tc_b_o
);
    logic [TIMER_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            cnt_q <= '0;
        end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tc_a_o = (cnt_q == TIMER_W'(TC_A));
    assign tc_b_o = (cnt_q == TIMER_W'(TC_B));
endmodule

// File: rtl/sata_link_supervisor.sv
// Link bring-up supervisor sitting between the AHCI control registers and oob_ctrl:
// issues offline/COMRESET pulses, retries on timeout and tracks link drops.
module sata_link_supervisor
    import sata_link_supervisor_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int OFFLINE_CYCLES = 75,
    parameter int RETRY_MAX      = 3,
    parameter int TIMER_W        = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               gtx_ready,
    input  logic               phy_ready,
    input  logic               ahci_comreset,
    input  logic               ahci_offline,
    output logic               set_offline,
    output logic               comreset_send,
    output logic               link_ok,
    output logic               link_fail,
    output logic [3:0]         retry_cnt,
    output logic [7:0]         fail_count,
    output logic [STATE_W-1:0] state
);
    sup_state_e state_q, state_d;
    logic [3:0] retry_q, retry_d;
    logic [7:0] fail_count_q, fail_count_d;
    logic       link_fail_q, link_fail_d;
    logic       link_ok_q, link_ok_d;
    logic       set_offline_q, set_offline_d;
    logic       comreset_q, comreset_d;
    logic       timer_clr, tc_offline, tc_timeout;

    sup_timer #(
        .TIMER_W (TIMER_W),
        .TC_A    (OFFLINE_CYCLES - 1),
        .TC_B    (TIMEOUT_CYCLES - 1)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (timer_clr),
        .tc_a_o (tc_offline),
        .tc_b_o (tc_timeout)
    );

    always_comb begin
        state_d       = state_q;
        retry_d       = retry_q;
        fail_count_d  = fail_count_q;
        link_fail_d   = link_fail_q;
        set_offline_d = 1'b0;
        comreset_d    = 1'b0;
        timer_clr     = 1'b0;

        if (ahci_offline) begin
            state_d       = ST_HOLD;
            set_offline_d = 1'b1;
        end else if (ahci_comreset) begin
            // Explicit restart clears the timer even when already in OFFLINE.
            state_d       = ST_OFFLINE;
            set_offline_d = 1'b1;
            retry_d       = 4'd0;
            link_fail_d   = 1'b0;
            timer_clr     = 1'b1;
        end else if ((!en || !gtx_ready) && state_q != ST_HOLD && state_q != ST_FAILED) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d       = ST_OFFLINE;
                    set_offline_d = 1'b1;
                    retry_d       = 4'd0;
                end
                ST_OFFLINE: if (tc_offline) state_d = ST_RESET;
                ST_RESET: begin
                    state_d    = ST_WAIT_LINK;
                    comreset_d = 1'b1;
                end
                ST_WAIT_LINK: begin
                    if (phy_ready) begin
                        state_d = ST_LINK_UP;
                        retry_d = 4'd0;
                    end else if (tc_timeout) begin
                        if (retry_q == 4'(RETRY_MAX)) begin
                            state_d     = ST_FAILED;
                            link_fail_d = 1'b1;
                        end else begin
                            state_d       = ST_OFFLINE;
                            retry_d       = retry_q + 4'd1;
                            set_offline_d = 1'b1;
                        end
                    end
                end
                ST_LINK_UP: begin
                    // oob_ctrl re-runs OOB on its own after a drop, so no offline pulse.
                    if (!phy_ready) begin
                        state_d      = ST_WAIT_LINK;
                        fail_count_d = sat_inc8(fail_count_q);
                    end
                end
                ST_FAILED, ST_HOLD: ;
                default: state_d = ST_IDLE;
            endcase
        end

        if (state_d != state_q) timer_clr = 1'b1;
        link_ok_d = (state_d == ST_LINK_UP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            retry_q       <= 4'd0;
            fail_count_q  <= 8'd0;
            link_fail_q   <= 1'b0;
            link_ok_q     <= 1'b0;
            set_offline_q <= 1'b0;
            comreset_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            retry_q       <= retry_d;
            fail_count_q  <= fail_count_d;
            link_fail_q   <= link_fail_d;
            link_ok_q     <= link_ok_d;
            set_offline_q <= set_offline_d;
            comreset_q    <= comreset_d;
        end
    end

    assign set_offline   = set_offline_q;
    assign comreset_send = comreset_q;
    assign link_ok       = link_ok_q;
    assign link_fail     = link_fail_q;
    assign retry_cnt     = retry_q;
    assign fail_count    = fail_count_q;
    assign state         = state_q;
endmodule

// File: tb/tb_sata_link_supervisor.sv
// Bench for sata_link_supervisor: directed vector table, multi-cycle corner
// sequences and a randomized run against a cycle-level reference model.
module tb_sata_link_supervisor;
    localparam int TO   = 100;
    localparam int OFF  = 8;
    localparam int RMAX = 2;

    logic clk = 1'b0;
    logic rst = 1'b1, en = 1'b0, gtx_ready = 1'b0, phy_ready = 1'b0;
    logic ahci_comreset = 1'b0, ahci_offline = 1'b0;
    logic set_offline, comreset_send, link_ok, link_fail;
    logic [3:0] retry_cnt;
    logic [7:0] fail_count;
    logic [2:0] state;

    sata_link_supervisor #(
        .TIMEOUT_CYCLES (TO),
        .OFFLINE_CYCLES (OFF),
        .RETRY_MAX      (RMAX),
        .TIMER_W        (20)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .gtx_ready     (gtx_ready),
        .phy_ready     (phy_ready),
        .ahci_comreset (ahci_comreset),
        .ahci_offline  (ahci_offline),
        .set_offline   (set_offline),
        .comreset_send (comreset_send),
        .link_ok       (link_ok),
        .link_fail     (link_fail),
        .retry_cnt     (retry_cnt),
        .fail_count    (fail_count),
        .state         (state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cr_pulses = 0;

    // Reference model: phase number, cycles spent in the phase, attempt counter.
    int m_phase = 0, m_dwell = 0, m_retries = 0, m_drops = 0;
    bit m_so = 0, m_cr = 0, m_lf = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [18:0] dut_vec();
        return {state, set_offline, comreset_send, link_ok, link_fail, retry_cnt, fail_count};
    endfunction

    function automatic logic [18:0] mdl_vec();
        return {3'(m_phase), m_so, m_cr, (m_phase == 4), m_lf, 4'(m_retries), 8'(m_drops)};
    endfunction

    task automatic model_step();
        int nxt = m_phase;
        bit restart = 0;
        m_so = 0;
        m_cr = 0;
        if (rst) begin
            m_phase = 0; m_dwell = 0; m_retries = 0; m_drops = 0; m_lf = 0;
            return;
        end
        if (ahci_offline) begin
            nxt = 6; m_so = 1;
        end else if (ahci_comreset) begin
            nxt = 1; m_so = 1; m_retries = 0; m_lf = 0; restart = 1;
        end else if (!(en && gtx_ready) && m_phase != 5 && m_phase != 6) begin
            nxt = 0;
        end else if (m_phase == 0) begin
            nxt = 1; m_so = 1; m_retries = 0;
        end else if (m_phase == 1) begin
            if (m_dwell + 1 >= OFF) nxt = 2;
        end else if (m_phase == 2) begin
            nxt = 3; m_cr = 1;
        end else if (m_phase == 3) begin
            if (phy_ready) begin
                nxt = 4; m_retries = 0;
            end else if (m_dwell + 1 >= TO) begin
                if (m_retries >= RMAX) begin
                    nxt = 5; m_lf = 1;
                end else begin
                    nxt = 1; m_retries++; m_so = 1;
                end
            end
        end else if (m_phase == 4 && !phy_ready) begin
            nxt = 3;
            if (m_drops < 255) m_drops++;
        end
        m_dwell = (nxt != m_phase || restart) ? 0 : m_dwell + 1;
        m_phase = nxt;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check("model", 32'(dut_vec()), 32'(mdl_vec()));
        check("pulse_excl", 32'(set_offline & comreset_send), 32'd0);
        if (comreset_send) cr_pulses++;
    endtask

    typedef struct {
        int         n;
        logic       r, e, g, p, ac, ao;
        logic [18:0] exp;
        string      nm;
    } vec_t;

    function automatic vec_t mk(input int n, input logic r, e, g, p, ac, ao,
                                input logic [2:0] st, input logic so, cr, lo, lf,
                                input logic [3:0] rc, input logic [7:0] fc, input string nm);
        vec_t v;
        v.n = n; v.r = r; v.e = e; v.g = g; v.p = p; v.ac = ac; v.ao = ao;
        v.exp = {st, so, cr, lo, lf, rc, fc};
        v.nm = nm;
        return v;
    endfunction

    vec_t vecs[20];

    initial begin
        vecs[0]  = mk(3,  1,1,1,0,0,0, 3'd0, 0,0,0,0, 4'd0, 8'd0, "reset");
        vecs[1]  = mk(1,  0,1,1,0,0,0, 3'd1, 1,0,0,0, 4'd0, 8'd0, "first_set_offline");
        vecs[2]  = mk(7,  0,1,1,0,0,0, 3'd1, 0,0,0,0, 4'd0, 8'd0, "offline_dwell");
        vecs[3]  = mk(1,  0,1,1,0,0,0, 3'd2, 0,0,0,0, 4'd0, 8'd0, "reset_state");
        vecs[4]  = mk(1,  0,1,1,0,0,0, 3'd3, 0,1,0,0, 4'd0, 8'd0, "comreset_pulse");
        vecs[5]  = mk(19, 0,1,1,0,0,0, 3'd3, 0,0,0,0, 4'd0, 8'd0, "wait_link");
        vecs[6]  = mk(1,  0,1,1,1,0,0, 3'd4, 0,0,1,0, 4'd0, 8'd0, "link_up");
        vecs[7]  = mk(1,  0,1,1,0,0,0, 3'd3, 0,0,0,0, 4'd0, 8'd1, "link_drop");
        vecs[8]  = mk(1,  0,1,1,1,0,0, 3'd4, 0,0,1,0, 4'd0, 8'd1, "relink");
        vecs[9]  = mk(1,  0,1,1,1,1,1, 3'd6, 1,0,0,0, 4'd0, 8'd1, "offline_beats_comreset");
        vecs[10] = mk(5,  0,1,1,1,0,0, 3'd6, 0,0,0,0, 4'd0, 8'd1, "hold_stays");
        vecs[11] = mk(1,  0,1,1,0,1,0, 3'd1, 1,0,0,0, 4'd0, 8'd1, "comreset_from_hold");
        vecs[12] = mk(8,  0,1,1,0,0,0, 3'd2, 0,0,0,0, 4'd0, 8'd1, "offline_to_reset");
        vecs[13] = mk(1,  0,1,1,0,0,0, 3'd3, 0,1,0,0, 4'd0, 8'd1, "comreset_again");
        vecs[14] = mk(10, 0,1,1,0,0,0, 3'd3, 0,0,0,0, 4'd0, 8'd1, "mid_wait");
        vecs[15] = mk(1,  1,1,1,0,0,0, 3'd0, 0,0,0,0, 4'd0, 8'd0, "rst_mid_wait");
        vecs[16] = mk(1,  0,1,1,0,0,0, 3'd1, 1,0,0,0, 4'd0, 8'd0, "restart");
        vecs[17] = mk(1,  0,0,1,0,0,0, 3'd0, 0,0,0,0, 4'd0, 8'd0, "en_low");
        vecs[18] = mk(2,  0,1,0,0,0,0, 3'd0, 0,0,0,0, 4'd0, 8'd0, "gtx_low");
        vecs[19] = mk(1,  0,1,1,0,0,0, 3'd1, 1,0,0,0, 4'd0, 8'd0, "gtx_back");

        foreach (vecs[i]) begin
            rst = vecs[i].r; en = vecs[i].e; gtx_ready = vecs[i].g; phy_ready = vecs[i].p;
            ahci_comreset = vecs[i].ac; ahci_offline = vecs[i].ao;
            repeat (vecs[i].n) cyc();
            check(vecs[i].nm, 32'(dut_vec()), 32'(vecs[i].exp));
            $display("vec %0d %s: outputs %05h expected %05h", i, vecs[i].nm, dut_vec(), vecs[i].exp);
        end
        ahci_comreset = 0; ahci_offline = 0; rst = 0; en = 1; gtx_ready = 1; phy_ready = 0;

        // Retries exhausted with no link.
        cr_pulses = 0;
        for (int k = 0; k < 2000 && state != 3'd5; k++) cyc();
        check("fail_reached", 32'(state), 32'd5);
        repeat (20) cyc();
        check("comreset_count", 32'(cr_pulses), 32'd3);
        check("fail_sticky", 32'(link_fail), 32'd1);
        check("fail_retry_cnt", 32'(retry_cnt), 32'(RMAX));
        en = 0;
        repeat (3) cyc();
        check("failed_ignores_en", 32'(state), 32'd5);
        en = 1; ahci_comreset = 1;
        cyc();
        ahci_comreset = 0;
        check("fail_cleared", 32'({link_fail, set_offline, state}), 32'({1'b0, 1'b1, 3'd1}));
        $display("seq retries: comreset pulses %0d, fail cleared %0b", cr_pulses, !link_fail);

        // Drop counter saturation.
        phy_ready = 1;
        for (int k = 0; k < 200 && !link_ok; k++) cyc();
        check("link_before_drops", 32'(link_ok), 32'd1);
        for (int k = 0; k < 300; k++) begin
            phy_ready = 0; cyc();
            phy_ready = 1; cyc();
        end
        check("fail_count_sat", 32'(fail_count), 32'd255);
        check("link_after_drops", 32'(link_ok), 32'd1);
        $display("seq drops: fail_count %0d after 300 drops", fail_count);

        // phy_ready arrives on the timeout cycle: link wins.
        phy_ready = 0; cyc();
        repeat (TO - 1) cyc();
        check("wait_before_timeout", 32'(state), 32'd3);
        phy_ready = 1; cyc();
        check("phy_beats_timeout", 32'({state, link_ok, retry_cnt}), 32'({3'd4, 1'b1, 4'd0}));
        // Plain timeout: one retry with a fresh offline pulse.
        phy_ready = 0; cyc();
        repeat (TO) cyc();
        check("timeout_retry", 32'({state, set_offline, retry_cnt}), 32'({3'd1, 1'b1, 4'd1}));
        $display("seq timeout boundary: state %0d retry %0d", state, retry_cnt);

        // Randomized run against the model.
        for (int k = 0; k < 4000; k++) begin
            rst           = ($urandom_range(999) < 2);
            en            = ($urandom_range(99) < 98);
            gtx_ready     = ($urandom_range(99) < 99);
            ahci_comreset = ($urandom_range(199) == 0);
            ahci_offline  = ($urandom_range(299) == 0);
            if ($urandom_range(99) < 3) phy_ready = ~phy_ready;
            cyc();
        end
        $display("random: 4000 cycles, state %0d fail_count %0d", state, fail_count);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
